// File: rtl/uart_factorial_ctrl_pkg.sv
// Shared definitions for the UART factorial sequencer: FSM state encodings
// and parameter helpers (result byte count, default largest operand per RES_W).
package uart_factorial_ctrl_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MULT    = 2'd1;
  localparam logic [1:0] ST_SEND    = 2'd2;
  localparam logic [1:0] ST_WAIT_TX = 2'd3;

  function automatic int fact_res_bytes(input int res_w, input int dbit);
    return res_w / dbit;
  endfunction

  // Largest N whose factorial still fits in res_w bits.
  function automatic int default_max_n(input int res_w);
    if (res_w >= 64) return 20;
    if (res_w >= 32) return 12;
    if (res_w >= 16) return 8;
    return 5;
  endfunction

endpackage

// File: rtl/fact_mult_seq.sv
// Iterative factorial datapath: holds operand, accumulator and multiplier k,
// advancing one multiply per cycle while run is high.
module fact_mult_seq #(
  parameter int DBIT  = 8,
  parameter int RES_W = 32,
  parameter int MAX_N = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [DBIT-1:0]  n_in,
  input  logic             run,
  output logic [RES_W-1:0] acc,
  output logic             done,
  output logic             ovf
);

  localparam int KW = DBIT + 1;
  localparam logic [KW-1:0] MAX_K = KW'(MAX_N);

  logic [DBIT-1:0]  n_reg;
  logic [KW-1:0]    k_reg;
  logic [RES_W-1:0] acc_reg;

  // k carries one extra bit so k > N terminates even for N = 2**DBIT-1.
  assign ovf  = {1'b0, n_reg} > MAX_K;
  assign done = ovf || (k_reg > {1'b0, n_reg});
  assign acc  = acc_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_reg   <= '0;
      k_reg   <= '0;
      acc_reg <= '0;
    end else if (load) begin
      n_reg   <= n_in;
      k_reg   <= KW'(2);
      acc_reg <= RES_W'(1);
    end else if (run) begin
      if (ovf) begin
        acc_reg <= '1;
      end else if (!done) begin
        acc_reg <= acc_reg * RES_W'(k_reg);
        k_reg   <= k_reg + KW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_factorial_ctrl.sv
// Sequencer between uart_rx and uart_tx: computes N! and streams it MSB-first.
// Define FACT_ECHO_EN to transmit the operand N ahead of the result bytes.
module uart_factorial_ctrl
  import uart_factorial_ctrl_pkg::*;
#(
  parameter int DBIT  = 8,
  parameter int RES_W = 32,
  parameter int MAX_N = default_max_n(RES_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBIT-1:0]  rx_dout,
  input  logic             rx_done_tick,
  output logic [DBIT-1:0]  tx_din,
  output logic             tx_start,
  input  logic             tx_done_tick,
  output logic             busy,
  output logic             err,
  output logic             drop,
  output logic [RES_W-1:0] result
);

  localparam int RES_BYTES = fact_res_bytes(RES_W, DBIT);
`ifdef FACT_ECHO_EN
  localparam int TX_BYTES = RES_BYTES + 1;
`else
  localparam int TX_BYTES = RES_BYTES;
`endif
  localparam int BW = $clog2(TX_BYTES + 1);
  localparam logic [BW-1:0] B_TOP = BW'(TX_BYTES - 1);

  logic [1:0]       state_reg;
  logic [BW-1:0]    b_reg;
  logic [DBIT-1:0]  tx_din_reg;
  logic             tx_start_reg;
  logic             err_reg;
  logic             drop_reg;
  logic [RES_W-1:0] result_reg;

  logic             load;
  logic             run;
  logic [RES_W-1:0] acc;
  logic             mult_done;
  logic             mult_ovf;
  logic [RES_W-1:0] acc_sh;
  logic [DBIT-1:0]  byte_sel;

  assign load = (state_reg == ST_IDLE) && rx_done_tick;
  assign run  = (state_reg == ST_MULT);

  fact_mult_seq #(
    .DBIT  (DBIT),
    .RES_W (RES_W),
    .MAX_N (MAX_N)
  ) u_mult (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .n_in  (rx_dout),
    .run   (run),
    .acc   (acc),
    .done  (mult_done),
    .ovf   (mult_ovf)
  );

`ifdef FACT_ECHO_EN
  logic [DBIT-1:0] echo_n_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      echo_n_reg <= '0;
    end else if (load) begin
      echo_n_reg <= rx_dout;
    end
  end
`endif

  // b counts down from the most significant byte; the echo slot sits above the result bytes.
  always_comb begin
    acc_sh   = acc >> (int'(b_reg) * DBIT);
    byte_sel = acc_sh[DBIT-1:0];
`ifdef FACT_ECHO_EN
    if (b_reg == BW'(RES_BYTES)) begin
      byte_sel = echo_n_reg;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      b_reg        <= '0;
      tx_din_reg   <= '0;
      tx_start_reg <= 1'b0;
      err_reg      <= 1'b0;
      drop_reg     <= 1'b0;
      result_reg   <= '0;
    end else begin
      tx_start_reg <= 1'b0;
      drop_reg     <= rx_done_tick && (state_reg != ST_IDLE);
      case (state_reg)
        ST_IDLE: begin
          if (rx_done_tick) begin
            err_reg   <= 1'b0;
            b_reg     <= B_TOP;
            state_reg <= ST_MULT;
          end
        end
        ST_MULT: begin
          if (mult_done) begin
            if (mult_ovf) err_reg <= 1'b1;
            state_reg <= ST_SEND;
          end
        end
        ST_SEND: begin
          result_reg   <= acc;
          tx_din_reg   <= byte_sel;
          tx_start_reg <= 1'b1;
          state_reg    <= ST_WAIT_TX;
        end
        default: begin
          if (tx_done_tick) begin
            if (b_reg == '0) begin
              state_reg <= ST_IDLE;
            end else begin
              b_reg     <= b_reg - BW'(1);
              state_reg <= ST_SEND;
            end
          end
        end
      endcase
    end
  end

  assign tx_din   = tx_din_reg;
  assign tx_start = tx_start_reg;
  assign busy     = (state_reg != ST_IDLE);
  assign err      = err_reg;
  assign drop     = drop_reg;
  assign result   = result_reg;

endmodule

// File: tb/tb_uart_factorial_ctrl.sv
// Directed bench for uart_factorial_ctrl; the bench models the uart_tx handshake.
// Build with FACT_ECHO_EN defined to expect the echoed operand byte.
module tb_uart_factorial_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_dout;
  logic        rx_done_tick;
  logic [7:0]  tx_din;
  logic        tx_start;
  logic        tx_done_tick;
  logic        busy;
  logic        err;
  logic        drop;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;
  int drop_cnt = 0;

  typedef struct {
    logic [0:7][7:0] b;
    int   nb;
    int   lat;
    bit   pulse_ok;
    bit   hold_ok;
    bit   timeout;
    int   extra;
    logic busy_end;
  } job_t;

  always #5 clk = ~clk;

  uart_factorial_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .rx_dout      (rx_dout),
    .rx_done_tick (rx_done_tick),
    .tx_din       (tx_din),
    .tx_start     (tx_start),
    .tx_done_tick (tx_done_tick),
    .busy         (busy),
    .err          (err),
    .drop         (drop),
    .result       (result)
  );

  always @(negedge clk) if (drop === 1'b1) drop_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: got still running want finished");
    $fatal(1);
  end

  // Expected byte stream: optional echo of N, then the 32-bit value MSB-first.
  function automatic void build_exp(input logic [7:0] n, input logic [31:0] val,
                                    output logic [0:7][7:0] e, output int cnt);
    e = '0;
    cnt = 0;
`ifdef FACT_ECHO_EN
    e[cnt] = n;
    cnt++;
`endif
    for (int i = 3; i >= 0; i--) begin
      e[cnt] = val[i*8 +: 8];
      cnt++;
    end
  endfunction

  // Mode 0 plain, 1 extra rx during WAIT_TX, 2 rx with last tx_done, 3 tx_done during MULT.
  task automatic run_job(input logic [7:0] n, input int nexp, input int mode, output job_t r);
    int w;
    r.b = '0; r.nb = 0; r.lat = 0; r.pulse_ok = 1; r.hold_ok = 1;
    r.timeout = 0; r.extra = 0; r.busy_end = 1'b1;
    @(negedge clk);
    rx_dout = n;
    rx_done_tick = 1'b1;
    do begin
      @(negedge clk);
      r.lat++;
      rx_done_tick = 1'b0;
      tx_done_tick = (mode == 3 && r.lat == 1);
      if (r.lat > 400) begin
        r.timeout = 1;
        tx_done_tick = 1'b0;
        return;
      end
    end while (tx_start !== 1'b1);
    tx_done_tick = 1'b0;
    for (int i = 0; i < nexp; i++) begin
      w = 0;
      while (tx_start !== 1'b1) begin
        @(negedge clk);
        w++;
        if (w > 60) begin
          r.timeout = 1;
          return;
        end
      end
      r.b[i] = tx_din;
      r.nb++;
      @(negedge clk);
      if (tx_start !== 1'b0) r.pulse_ok = 0;
      if (mode == 1 && i == 1) begin
        rx_dout = 8'd7;
        rx_done_tick = 1'b1;
      end
      @(negedge clk);
      rx_done_tick = 1'b0;
      @(negedge clk);
      if (tx_din !== r.b[i]) r.hold_ok = 0;
      tx_done_tick = 1'b1;
      if (mode == 2 && i == nexp - 1) begin
        rx_dout = 8'd9;
        rx_done_tick = 1'b1;
      end
      @(negedge clk);
      tx_done_tick = 1'b0;
      rx_done_tick = 1'b0;
      if (i == nexp - 1) r.busy_end = busy;
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (tx_start === 1'b1) r.extra++;
    end
    $display("job n=%0d mode=%0d bytes=%h nb=%0d lat=%0d result=%h err=%b",
             n, mode, r.b, r.nb, r.lat, result, err);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx_dout = '0;
    rx_done_tick = 1'b0;
    tx_done_tick = 1'b0;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx_din !== 8'h00)   begin errors++; $display("FAIL reset tx_din: got %h want 00", tx_din); end
    checks++; if (tx_start !== 1'b0)  begin errors++; $display("FAIL reset tx_start: got %b want 0", tx_start); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
    checks++; if (err !== 1'b0)       begin errors++; $display("FAIL reset err: got %b want 0", err); end
    checks++; if (drop !== 1'b0)      begin errors++; $display("FAIL reset drop: got %b want 0", drop); end
    checks++; if (result !== 32'h0)   begin errors++; $display("FAIL reset result: got %h want 0", result); end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    $display("reset released busy=%b", busy);
  endtask

  task automatic test_fact(input logic [7:0] n, input logic [31:0] val,
                           input logic exp_err, input int exp_lat);
    job_t r;
    logic [0:7][7:0] e;
    int ne;
    build_exp(n, val, e, ne);
    run_job(n, ne, 0, r);
    checks++; if (r.timeout) begin errors++; $display("FAIL fact n=%0d timeout: got %0d bytes want %0d", n, r.nb, ne); end
    checks++; if (r.nb != ne) begin errors++; $display("FAIL fact n=%0d count: got %0d want %0d", n, r.nb, ne); end
    for (int i = 0; i < ne; i++) begin
      checks++;
      if (r.b[i] !== e[i]) begin errors++; $display("FAIL fact n=%0d byte%0d: got %h want %h", n, i, r.b[i], e[i]); end
    end
    checks++; if (r.lat != exp_lat) begin errors++; $display("FAIL fact n=%0d latency: got %0d want %0d", n, r.lat, exp_lat); end
    checks++; if (!r.pulse_ok)  begin errors++; $display("FAIL fact n=%0d tx_start width: got >1 cycle want 1", n); end
    checks++; if (!r.hold_ok)   begin errors++; $display("FAIL fact n=%0d tx_din hold: got changed want stable", n); end
    checks++; if (r.busy_end !== 1'b0) begin errors++; $display("FAIL fact n=%0d busy after last: got %b want 0", n, r.busy_end); end
    checks++; if (r.extra != 0) begin errors++; $display("FAIL fact n=%0d extra tx_start: got %0d want 0", n, r.extra); end
    checks++; if (result !== val) begin errors++; $display("FAIL fact n=%0d result: got %h want %h", n, result, val); end
    checks++; if (err !== exp_err) begin errors++; $display("FAIL fact n=%0d err: got %b want %b", n, err, exp_err); end
  endtask

  task automatic test_drop();
    job_t r;
    logic [0:7][7:0] e;
    int ne;
    int d0;
    d0 = drop_cnt;
    build_exp(8'd6, 32'h0000_02D0, e, ne);
    run_job(8'd6, ne, 1, r);
    checks++; if (r.nb != ne) begin errors++; $display("FAIL drop count: got %0d want %0d", r.nb, ne); end
    for (int i = 0; i < ne; i++) begin
      checks++;
      if (r.b[i] !== e[i]) begin errors++; $display("FAIL drop byte%0d: got %h want %h", i, r.b[i], e[i]); end
    end
    checks++; if (drop_cnt - d0 != 1) begin errors++; $display("FAIL drop pulses: got %0d want 1", drop_cnt - d0); end
    checks++; if (r.extra != 0) begin errors++; $display("FAIL drop second job started: got %0d want 0", r.extra); end
    checks++; if (result !== 32'h0000_02D0) begin errors++; $display("FAIL drop result: got %h want 000002d0", result); end
  endtask

  task automatic test_back_to_back();
    job_t r;
    logic [0:7][7:0] e;
    int ne;
    int d0;
    d0 = drop_cnt;
    build_exp(8'd3, 32'h6, e, ne);
    run_job(8'd3, ne, 2, r);
    checks++; if (r.b[ne-1] !== e[ne-1]) begin errors++; $display("FAIL b2b last byte: got %h want %h", r.b[ne-1], e[ne-1]); end
    checks++; if (r.busy_end !== 1'b0) begin errors++; $display("FAIL b2b busy: got %b want 0", r.busy_end); end
    checks++; if (drop_cnt - d0 != 1) begin errors++; $display("FAIL b2b drop pulses: got %0d want 1", drop_cnt - d0); end
    checks++; if (r.extra != 0) begin errors++; $display("FAIL b2b job started: got %0d want 0", r.extra); end
    build_exp(8'd2, 32'h2, e, ne);
    run_job(8'd2, ne, 0, r);
    checks++; if (r.b[ne-1] !== e[ne-1] || r.nb != ne) begin errors++; $display("FAIL b2b follow-up: got %h/%0d want %h/%0d", r.b[ne-1], r.nb, e[ne-1], ne); end
  endtask

  task automatic test_tx_done_ignored();
    job_t r;
    logic [0:7][7:0] e;
    int ne;
    @(negedge clk);
    tx_done_tick = 1'b1;
    @(negedge clk);
    tx_done_tick = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || tx_start !== 1'b0) begin errors++; $display("FAIL idle tx_done: got busy=%b start=%b want 0 0", busy, tx_start); end
    build_exp(8'd4, 32'h18, e, ne);
    run_job(8'd4, ne, 3, r);
    checks++; if (r.nb != ne) begin errors++; $display("FAIL mult tx_done count: got %0d want %0d", r.nb, ne); end
    for (int i = 0; i < ne; i++) begin
      checks++;
      if (r.b[i] !== e[i]) begin errors++; $display("FAIL mult tx_done byte%0d: got %h want %h", i, r.b[i], e[i]); end
    end
  endtask

  task automatic test_reset_mid();
    job_t r;
    logic [0:7][7:0] e;
    int ne;
    int w;
    @(negedge clk);
    rx_dout = 8'd5;
    rx_done_tick = 1'b1;
    @(negedge clk);
    rx_done_tick = 1'b0;
    w = 0;
    while (tx_start !== 1'b1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL midreset reach send: got %b want 1", tx_start); end
    #1 reset = 1'b0;
    #1;
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL midreset tx_start: got %b want 0", tx_start); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL midreset busy: got %b want 0", busy); end
    checks++; if (result !== 32'h0)  begin errors++; $display("FAIL midreset result: got %h want 0", result); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    $display("mid-job reset applied and released");
    build_exp(8'd3, 32'h6, e, ne);
    run_job(8'd3, ne, 0, r);
    checks++; if (r.nb != ne) begin errors++; $display("FAIL midreset count: got %0d want %0d", r.nb, ne); end
    for (int i = 0; i < ne; i++) begin
      checks++;
      if (r.b[i] !== e[i]) begin errors++; $display("FAIL midreset byte%0d: got %h want %h", i, r.b[i], e[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_fact(8'd5,  32'h0000_0078, 1'b0, 7);
    test_fact(8'd0,  32'h0000_0001, 1'b0, 3);
    test_fact(8'd1,  32'h0000_0001, 1'b0, 3);
    test_fact(8'd12, 32'h1C8C_FC00, 1'b0, 14);
    test_fact(8'd13, 32'hFFFF_FFFF, 1'b1, 3);
    test_fact(8'd4,  32'h0000_0018, 1'b0, 6);
    test_drop();
    test_back_to_back();
    test_tx_done_ignored();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
